// File: rtl/div_pkg.sv
// Shared definitions for the radix-2 restoring divider: state encodings,
// datapath widths and the iteration count.
package div_pkg;

    localparam int unsigned RegWidth       = 32;
    localparam int unsigned DoubleRegWidth = 64;
    localparam int unsigned DivIterations  = 32;
    localparam int unsigned CntWidth       = 6;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_DONE   = 2'b11
    } div_state_e;

    // Magnitude of a 32-bit operand when treated as signed; unchanged otherwise.
    function automatic logic [RegWidth-1:0] div_mag(input logic [RegWidth-1:0] v,
                                                    input logic                sgn);
        return (sgn && v[RegWidth-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider, 32 steps per operation, result {remainder, quotient}.
// Optional DIV_EARLY_TERM_EN: finish at once when |dividend| < |divisor|.
module div
    import div_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      signed_i,
    input  logic [RegWidth-1:0]       data1_i,
    input  logic [RegWidth-1:0]       data2_i,
    input  logic                      annul_i,
    output logic [DoubleRegWidth-1:0] result_o,
    output logic                      done_o,
    output logic [1:0]                state_o
);

    // Handshake: start_i is held until done_o is seen; done_o/result_o then hold
    // until start_i drops, which returns the block to IDLE on the same edge.

    div_state_e                state_q, state_d;
    logic [CntWidth-1:0]       cnt_q, cnt_d;
    logic [DoubleRegWidth:0]   pr_q, pr_d;
    logic [RegWidth-1:0]       divisor_q, divisor_d;
    logic                      signed_q, signed_d;
    logic                      sign1_q, sign1_d;
    logic                      sign2_q, sign2_d;
    logic [DoubleRegWidth-1:0] result_q, result_d;
    logic                      done_q, done_d;

    logic [RegWidth-1:0]       mag1, mag2;
    logic [DoubleRegWidth:0]   pr_sh, pr_step;
    logic [RegWidth:0]         diff;
    logic [RegWidth-1:0]       quot, rem, quot_fix, rem_fix;
    logic                      last_step, early_term;

    assign mag1 = div_mag(data1_i, signed_i);
    assign mag2 = div_mag(data2_i, signed_i);

`ifdef DIV_EARLY_TERM_EN
    assign early_term = (mag1 < mag2);
`else
    assign early_term = 1'b0;
`endif

    // One restoring step: shift, trial-subtract, keep the difference if it fits.
    assign pr_sh   = {pr_q[DoubleRegWidth-1:0], 1'b0};
    assign diff    = pr_sh[DoubleRegWidth:RegWidth] - {1'b0, divisor_q};
    assign pr_step = diff[RegWidth] ? pr_sh : {diff, pr_sh[RegWidth-1:1], 1'b1};

    assign quot     = pr_step[RegWidth-1:0];
    assign rem      = pr_step[DoubleRegWidth-1:RegWidth];
    assign quot_fix = (signed_q && (sign1_q ^ sign2_q)) ? (~quot + 1'b1) : quot;
    assign rem_fix  = (signed_q && sign1_q) ? (~rem + 1'b1) : rem;

    assign last_step = (cnt_q == CntWidth'(DivIterations - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (annul_i) begin
            state_d = DIV_IDLE;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (start_i) begin
                        if (data2_i == '0)   state_d = DIV_BYZERO;
                        else if (early_term) state_d = DIV_DONE;
                        else                 state_d = DIV_ON;
                    end
                end
                DIV_BYZERO: state_d = start_i ? DIV_DONE : DIV_IDLE;
                DIV_ON: begin
                    if (!start_i)       state_d = DIV_IDLE;
                    else if (last_step) state_d = DIV_DONE;
                end
                DIV_DONE: begin
                    if (!start_i) state_d = DIV_IDLE;
                end
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        pr_d      = pr_q;
        divisor_d = divisor_q;
        signed_d  = signed_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        result_d  = result_q;
        done_d    = (state_d == DIV_DONE);
        if (!annul_i) begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (start_i) begin
                        cnt_d     = '0;
                        pr_d      = {{(RegWidth+1){1'b0}}, mag1};
                        divisor_d = mag2;
                        signed_d  = signed_i;
                        sign1_d   = data1_i[RegWidth-1];
                        sign2_d   = data2_i[RegWidth-1];
                        // The original dividend already carries the right remainder sign.
                        if (data2_i != '0 && early_term) result_d = {data1_i, {RegWidth{1'b0}}};
                    end
                end
                DIV_BYZERO: begin
                    if (start_i) result_d = '0;
                end
                DIV_ON: begin
                    if (start_i) begin
                        cnt_d = cnt_q + 1'b1;
                        pr_d  = pr_step;
                        if (last_step) result_d = {rem_fix, quot_fix};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            pr_q      <= '0;
            divisor_q <= '0;
            signed_q  <= 1'b0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pr_q      <= pr_d;
            divisor_q <= divisor_d;
            signed_q  <= signed_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign result_o = result_q;
    assign done_o   = done_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_div.sv
// Directed plus randomized bench for the div block with a result scoreboard.
module tb_div;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        done_o;
  logic [1:0]  state_o;

  logic [63:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  div dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .annul_i  (annul_i),
    .result_o (result_o),
    .done_o   (done_o),
    .state_o  (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'h0) return 64'h0;
    if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  function automatic int ref_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    if (b == 32'h0) return 2;
`ifdef DIV_EARLY_TERM_EN
    if (ma < mb) return 1;
`endif
    return 33;
  endfunction

  // driver: one full transaction with hold-check and release
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    int          lat;
    logic        got;
    logic [63:0] exp;
    start_i  = 1'b1;
    signed_i = sgn;
    data1_i  = a;
    data2_i  = b;
    exp_q.push_back(exp_res);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      lat++;
      if (i == 0) begin
        data1_i  = $urandom;
        data2_i  = $urandom;
        signed_i = ~sgn;
      end
      if (done_o) got = 1'b1;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    exp = exp_q.pop_front();
    if (got) begin
      check({tag, "_res"}, result_o, exp);
      step();
      step();
      check({tag, "_hold_done"}, 64'(done_o), 64'h1);
      check({tag, "_hold_res"}, result_o, exp);
    end
    start_i = 1'b0;
    step();
    check({tag, "_rel_done"}, 64'(done_o), 64'h0);
    check({tag, "_rel_state"}, 64'(state_o), 64'(DIV_IDLE));
  endtask

  task automatic run_model(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    run_op(tag, sgn, a, b, ref_div(sgn, a, b), ref_lat(sgn, a, b));
  endtask

  initial begin
    int done_seen;
    rst      = 1'b1;
    start_i  = 1'b1;
    signed_i = 1'b0;
    data1_i  = 32'd5;
    data2_i  = 32'd1;
    annul_i  = 1'b0;
    repeat (3) step();
    check("rst_done", 64'(done_o), 64'h0);
    check("rst_res", result_o, 64'h0);
    check("rst_state", 64'(state_o), 64'(DIV_IDLE));
    rst     = 1'b0;
    start_i = 1'b0;
    step();

    run_op("s7_2", 1'b1, 32'd7, 32'd2, 64'h00000001_00000003, 33);
    run_op("sm7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
    run_op("uff_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 64'h00000001_7FFFFFFF, 33);
    run_op("div0", 1'b1, 32'h1234_5678, 32'h0, 64'h0, 2);
    run_op("ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 33);
`ifdef DIV_EARLY_TERM_EN
    run_op("u3_10", 1'b0, 32'd3, 32'd10, 64'h00000003_00000000, 1);
`else
    run_op("u3_10", 1'b0, 32'd3, 32'd10, 64'h00000003_00000000, 33);
`endif

    // annul at step 10 with start still high; the restart must be clean
    start_i   = 1'b1;
    signed_i  = 1'b0;
    data1_i   = 32'd5;
    data2_i   = 32'd3;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done_o) done_seen++;
    end
    annul_i = 1'b1;
    step();
    check("annul_nodone", 64'(done_seen), 64'h0);
    check("annul_done", 64'(done_o), 64'h0);
    check("annul_state", 64'(state_o), 64'(DIV_IDLE));
    annul_i = 1'b0;
    run_op("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

    // start dropped mid-operation aborts
    start_i = 1'b1;
    data1_i = 32'd1000;
    data2_i = 32'd3;
    repeat (5) step();
    start_i = 1'b0;
    step();
    check("abort_state", 64'(state_o), 64'(DIV_IDLE));
    check("abort_done", 64'(done_o), 64'h0);

    // synchronous reset at step 20, start held high
    start_i = 1'b1;
    signed_i = 1'b1;
    data1_i = 32'hFFFF_FF00;
    data2_i = 32'd9;
    repeat (20) step();
    rst = 1'b1;
    step();
    check("mrst_state", 64'(state_o), 64'(DIV_IDLE));
    check("mrst_done", 64'(done_o), 64'h0);
    check("mrst_res", result_o, 64'h0);
    rst     = 1'b0;
    start_i = 1'b0;
    step();
    run_model("post_rst", 1'b1, 32'hFFFF_FF00, 32'd9);

    // randomized mix, back-to-back
    for (int k = 0; k < 8; k++) begin
      logic        s;
      logic [31:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = (k % 2 == 0) ? $urandom : 32'($urandom_range(0, 200));
      b = (k == 5) ? 32'h0 : ((k % 3 == 0) ? $urandom : 32'($urandom_range(1, 300)));
      if (k == 6) b = 32'hFFFF_FFFF;
      run_model($sformatf("rnd%0d", k), s, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
